// File: rtl/dram_port_arbiter_if.sv
// ============================================================================
//  Module      : dram_port_arbiter_if
//  Description : Requester-side handshake bundle for dram_port_arbiter.
//                One instance per requester.
//                  req    requester -> arbiter  access request, held until ack
//                  addr   requester -> arbiter  access address, held with req
//                  wdata  requester -> arbiter  write data, held with req
//                  we     requester -> arbiter  1 = write, 0 = read
//                  ack    arbiter -> requester  one-cycle completion pulse
//                  err    arbiter -> requester  write into read-only window
//                  rdata  arbiter -> requester  read data, valid with ack
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_port_arbiter_if;
  logic       req;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       ack;
  logic       err;
  logic [7:0] rdata;

  modport master (output req, addr, wdata, we, input ack, err, rdata);
  modport slave  (input req, addr, wdata, we, output ack, err, rdata);
endinterface

`default_nettype wire

// File: rtl/dram_port_arbiter.sv
// ============================================================================
//  Module      : dram_port_arbiter
//  Description : Two-requester arbiter/sequencer for the 8-bit data RAM and
//                memory-mapped I/O port. One access per granted cycle,
//                registered read data with a one-cycle ack, and suppression
//                (with err) of writes into the read-only input window.
//  Ports       : clk, rst_n      clock, asynchronous active-low reset
//                r0, r1          requester handshakes (datapath, loader)
//                m_addr/m_data/m_mw  RAM address, write data, write enable
//                m_q             RAM combinational read data
//                grant           one-hot current owner, 2'b00 = idle
//                busy            OR of grant bits
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_port_arbiter #(
  parameter bit         RR_EN = 1'b1,
  parameter logic [7:0] RO_LO = 8'd248,
  parameter logic [7:0] RO_HI = 8'd249
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dram_port_arbiter_if.slave   r0,
  dram_port_arbiter_if.slave   r1,
  output logic [7:0]           m_addr,
  output logic [7:0]           m_data,
  output logic                 m_mw,
  input  logic [7:0]           m_q,
  output logic [1:0]           grant,
  output logic                 busy
);

  // The state encoding is the grant vector itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_last;
  logic       w_next_last;
  logic       w_elig0;
  logic       w_elig1;
  logic       w_done0;
  logic       w_done1;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_err0;
  logic       r_err1;
  logic [7:0] r_rdata0;
  logic [7:0] r_rdata1;

  function automatic logic in_ro(input logic [7:0] a);
    return (a >= RO_LO) && (a <= RO_HI);
  endfunction

  // Next-state decision and combinational RAM port drive.
  always_comb begin
    // The current owner is excluded: it still holds req until it sees ack,
    // and this exclusion is also what forces hand-off under contention.
    w_elig0 = r0.req && (r_state != G0);
    w_elig1 = r1.req && (r_state != G1);

    w_next_state = IDLE;
    if (w_elig0 && w_elig1) begin
      if (RR_EN) begin
        w_next_state = r_last ? G0 : G1;
      end else begin
        w_next_state = G0;
      end
    end else if (w_elig0) begin
      w_next_state = G0;
    end else if (w_elig1) begin
      w_next_state = G1;
    end

    w_next_last = r_last;
    if (w_next_state == G0) begin
      w_next_last = 1'b0;
    end else if (w_next_state == G1) begin
      w_next_last = 1'b1;
    end

    m_addr  = 8'h00;
    m_data  = 8'h00;
    m_mw    = 1'b0;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    case (r_state)
      G0: begin
        m_addr  = r0.addr;
        m_data  = r0.wdata;
        // req gates the strobe so a requester withdrawing mid-grant aborts.
        m_mw    = r0.we & r0.req & ~in_ro(r0.addr);
        w_done0 = r0.req;
      end
      G1: begin
        m_addr  = r1.addr;
        m_data  = r1.wdata;
        m_mw    = r1.we & r1.req & ~in_ro(r1.addr);
        w_done1 = r1.req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;   // makes requester 0 the first tie winner
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= 8'h00;
      r_rdata1 <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
      r_ack0  <= w_done0;
      r_ack1  <= w_done1;
      r_err0  <= w_done0 & r0.we & in_ro(r0.addr);
      r_err1  <= w_done1 & r1.we & in_ro(r1.addr);
      if (w_done0 && !r0.we) begin
        r_rdata0 <= m_q;
      end
      if (w_done1 && !r1.we) begin
        r_rdata1 <= m_q;
      end
    end
  end

  assign r0.ack   = r_ack0;
  assign r1.ack   = r_ack1;
  assign r0.err   = r_err0;
  assign r1.err   = r_err1;
  assign r0.rdata = r_rdata0;
  assign r1.rdata = r_rdata1;
  assign grant    = r_state;
  assign busy     = |r_state;

endmodule

`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
// ============================================================================
//  Module      : tb_dram_port_arbiter
//  Description : Self-checking bench for dram_port_arbiter. A round-robin
//                instance is fully scoreboarded against a per-requester
//                in-order memory model; a fixed-priority instance shares the
//                same requester inputs for grant-order comparisons.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_port_arbiter_if r0 ();
  dram_port_arbiter_if r1 ();
  dram_port_arbiter_if fp0 ();
  dram_port_arbiter_if fp1 ();

  logic [7:0] m_addr, m_data, m_q;
  logic       m_mw;
  logic [1:0] grant;
  logic       busy;
  logic [7:0] fp_addr, fp_data;
  logic       fp_mw;
  logic [1:0] fp_grant;
  logic       fp_busy;

  dram_port_arbiter #(.RR_EN(1'b1), .RO_LO(8'd248), .RO_HI(8'd249)) dut (
    .clk(clk), .rst_n(rst_n), .r0(r0), .r1(r1),
    .m_addr(m_addr), .m_data(m_data), .m_mw(m_mw), .m_q(m_q),
    .grant(grant), .busy(busy)
  );

  dram_port_arbiter #(.RR_EN(1'b0), .RO_LO(8'd248), .RO_HI(8'd249)) dut_fp (
    .clk(clk), .rst_n(rst_n), .r0(fp0), .r1(fp1),
    .m_addr(fp_addr), .m_data(fp_data), .m_mw(fp_mw), .m_q(8'h00),
    .grant(fp_grant), .busy(fp_busy)
  );

  assign fp0.req   = r0.req;
  assign fp0.addr  = r0.addr;
  assign fp0.wdata = r0.wdata;
  assign fp0.we    = r0.we;
  assign fp1.req   = r1.req;
  assign fp1.addr  = r1.addr;
  assign fp1.wdata = r1.wdata;
  assign fp1.we    = r1.we;

  // RAM + I/O block: 248/249 are input ports, 250..255 read as zero.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ioa = 8'hC3;
  logic [7:0] iob = 8'h3C;
  always @(posedge clk) if (m_mw) mem[m_addr] <= m_data;
  assign m_q = (m_addr == 8'd248) ? ioa :
               (m_addr == 8'd249) ? iob :
               (m_addr >= 8'd250) ? 8'h00 : mem[m_addr];

  // Reference model: each requester works in its own address region, so an
  // in-order memory per requester predicts every response exactly.
  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  logic [7:0] ref_mem [256];
  logic [7:0] last_rd [2];
  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations on each ack and checks port invariants.
  logic prev_ack0 = 1'b0;
  logic prev_ack1 = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      check("grant_legal", {31'b0, grant != 2'b11}, 1);
      check("busy", {31'b0, busy}, {31'b0, |grant});
      if (m_mw) check("ro_write_blocked", {31'b0, (m_addr >= 8'd248) && (m_addr <= 8'd249)}, 0);
      check("err0_only_with_ack", {31'b0, r0.err & ~r0.ack}, 0);
      check("err1_only_with_ack", {31'b0, r1.err & ~r1.ack}, 0);
      check("ack0_one_cycle", {31'b0, r0.ack & prev_ack0}, 0);
      check("ack1_one_cycle", {31'b0, r1.ack & prev_ack1}, 0);
      if (r0.ack) begin
        check("ack0_expected", {31'b0, q0.size() != 0}, 1);
        if (q0.size() != 0) begin
          mon_e = q0.pop_front();
          check("err0", {31'b0, r0.err}, {31'b0, mon_e.err});
          check("rdata0", {24'b0, r0.rdata}, {24'b0, mon_e.rdata});
        end
      end
      if (r1.ack) begin
        check("ack1_expected", {31'b0, q1.size() != 0}, 1);
        if (q1.size() != 0) begin
          mon_e = q1.pop_front();
          check("err1", {31'b0, r1.err}, {31'b0, mon_e.err});
          check("rdata1", {24'b0, r1.rdata}, {24'b0, mon_e.rdata});
        end
      end
    end
    prev_ack0 <= r0.ack;
    prev_ack1 <= r1.ack;
  end

  task automatic drive(input int n, input logic req, input logic [7:0] a,
                       input logic we, input logic [7:0] wd);
    if (n == 0) begin
      r0.req = req; r0.addr = a; r0.we = we; r0.wdata = wd;
    end else begin
      r1.req = req; r1.addr = a; r1.we = we; r1.wdata = wd;
    end
  endtask

  task automatic drop(input int n);
    if (n == 0) r0.req = 1'b0;
    else        r1.req = 1'b0;
  endtask

  // Issue one access at a negedge; returns at the negedge that shows ack,
  // with req still high so the caller may go back-to-back.
  task automatic do_txn(input int n, input logic [7:0] a, input logic we,
                        input logic [7:0] wd, input int min_lat, input int max_lat);
    exp_t e;
    int   lat;
    e.err = we && (a == 8'd248 || a == 8'd249);
    if (we) begin
      if (!e.err) ref_mem[a] = wd;
      e.rdata = last_rd[n];
    end else begin
      e.rdata = (a == 8'd248) ? ioa : (a == 8'd249) ? iob :
                (a >= 8'd250) ? 8'h00 : ref_mem[a];
      last_rd[n] = e.rdata;
    end
    if (n == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(n, 1'b1, a, we, wd);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!((n == 0) ? r0.ack : r1.ack) && lat < 20);
    if (lat >= 20) begin
      check($sformatf("ack_timeout%0d", n), 0, 1);
      drop(n);
      if (n == 0) void'(q0.pop_back());
      else        void'(q1.pop_back());
    end else begin
      check($sformatf("latency%0d", n), {31'b0, lat >= min_lat && lat <= max_lat}, 1);
    end
  endtask

  task automatic rand_run(input int n, input int cnt);
    logic [7:0] a;
    int gap;
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 7) == 0) a = 8'(248 + $urandom_range(0, 7));
      else                           a = 8'(n * 100 + $urandom_range(0, 99));
      do_txn(n, a, 1'($urandom_range(0, 1)), 8'($urandom), 2, 3);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        drop(n);
        repeat (gap) @(negedge clk);
      end
    end
    drop(n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drop(0);
    drop(1);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] g_rr [6];
  logic [1:0] g_fp [6];
  logic [1:0] g_exp [6];
  int bad;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    drive(0, 1'b0, 8'h00, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00, 1'b0, 8'h00);
    g_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    // Reset defaults
    repeat (2) @(negedge clk);
    check("rst_grant", {30'b0, grant}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_ack", {30'b0, r0.ack, r1.ack}, 0);
    check("rst_err", {30'b0, r0.err, r1.err}, 0);
    check("rst_rdata", {16'b0, r0.rdata, r1.rdata}, 0);
    check("rst_mport", {15'b0, m_addr, m_data, m_mw}, 0);
    check("rst_fp_grant", {30'b0, fp_grant}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of a granted write
    drive(0, 1'b1, 8'd10, 1'b1, 8'hA5);
    @(posedge clk);
    #2;
    check("midwr_grant", {30'b0, grant}, 2'b01);
    check("midwr_mw_live", {31'b0, m_mw}, 1);
    rst_n = 1'b0;
    #1;
    check("midwr_mw_drop", {31'b0, m_mw}, 0);
    check("midwr_grant_rst", {30'b0, grant}, 0);
    check("midwr_addr_rst", {24'b0, m_addr}, 0);
    drop(0);
    @(posedge clk);
    #1;
    check("midwr_mem10", {24'b0, mem[10]}, 0);
    check("midwr_ack", {30'b0, r0.ack, r1.ack}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // R0 write then read, isolated (latency exactly 2)
    do_txn(0, 8'd20, 1'b1, 8'h5A, 2, 2);
    drop(0);
    @(negedge clk);
    do_txn(0, 8'd20, 1'b0, 8'h00, 2, 2);
    drop(0);
    @(negedge clk);

    // R1: read-only window and high pass-through addresses
    do_txn(1, 8'd248, 1'b1, 8'h77, 2, 2);
    drop(1);
    @(negedge clk);
    do_txn(1, 8'd249, 1'b0, 8'h00, 2, 2);
    drop(1);
    @(negedge clk);
    do_txn(1, 8'd250, 1'b1, 8'hEE, 2, 2);
    drop(1);
    check("pass_through_250", {24'b0, mem[250]}, 8'hEE);
    @(negedge clk);
    do_txn(1, 8'd250, 1'b0, 8'h00, 2, 2);
    drop(1);
    @(negedge clk);

    // R0 withdraws req during its own grant cycle
    drive(0, 1'b1, 8'd30, 1'b1, 8'h99);
    @(negedge clk);
    check("abort_grant", {30'b0, grant}, 2'b01);
    check("abort_mw_live", {31'b0, m_mw}, 1);
    drop(0);
    #1;
    check("abort_mw_drop", {31'b0, m_mw}, 0);
    @(negedge clk);
    check("abort_idle", {30'b0, grant}, 0);
    check("abort_no_ack", {31'b0, r0.ack}, 0);
    @(negedge clk);
    check("abort_no_ack2", {31'b0, r0.ack}, 0);
    check("abort_mem30", {24'b0, mem[30]}, 0);

    // Both requesting back-to-back from idle after reset
    do_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) do_txn(0, 8'(40 + i), 1'b0, 8'h00, 2, 3);
        drop(0);
      end
      begin
        for (int i = 0; i < 4; i++) do_txn(1, 8'(140 + i), 1'b1, 8'(i + 1), 2, 3);
        drop(1);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          g_rr[i] = grant;
          g_fp[i] = fp_grant;
        end
      end
    join
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_grant_seq%0d", i), {30'b0, g_rr[i]}, {30'b0, g_exp[i]});
      check($sformatf("fp_grant_seq%0d", i), {30'b0, g_fp[i]}, {30'b0, g_exp[i]});
    end
    repeat (2) @(negedge clk);

    // Tie from idle after R0 was last served: round-robin picks R1, fixed picks R0
    do_reset();
    do_txn(0, 8'd41, 1'b0, 8'h00, 2, 2);
    drop(0);
    repeat (2) @(negedge clk);
    fork
      begin do_txn(0, 8'd42, 1'b0, 8'h00, 2, 3); drop(0); end
      begin do_txn(1, 8'd142, 1'b0, 8'h00, 2, 3); drop(1); end
      begin
        @(negedge clk);
        check("tie_rr_grant", {30'b0, grant}, 2'b10);
        check("tie_fp_grant", {30'b0, fp_grant}, 2'b01);
      end
    join
    repeat (2) @(negedge clk);

    // Randomized concurrent traffic
    fork
      rand_run(0, 40);
      rand_run(1, 40);
    join
    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    bad = 0;
    for (int i = 0; i < 200; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("ram_contents", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Two-requester arbiter and sequencer for the 8-bit data RAM / memory-mapped I/O block. It shares the single RAM port (ADDR, DATA, MW, Q) between the processor datapath (requester 0) and a loader/debug master (requester 1), one access per granted cycle. It returns registered read data with a one-cycle ACK pulse, and flags illegal writes into the read-only input window.

## Interface
Parameters:
- RR_EN, 1, 1 = round-robin on contention; 0 = fixed priority, requester 0 wins ties
- RO_LO, 8'd248, first read-only I/O address (IOA)
- RO_HI, 8'd249, last read-only I/O address (IOB)

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RESETN  in  1  asynchronous, active-low reset
- R0_REQ / R1_REQ  in  1  access request; held until ACK
- R0_ADDR / R1_ADDR  in  8  access address; held with REQ
- R0_WDATA / R1_WDATA  in  8  write data; held with REQ
- R0_WE / R1_WE  in  1  1 = write, 0 = read; held with REQ
- R0_ACK / R1_ACK  out  1  one-cycle completion pulse (registered)
- R0_ERR / R1_ERR  out  1  valid with ACK: write to RO_LO..RO_HI was suppressed
- R0_RDATA / R1_RDATA  out  8  read data, valid with ACK; holds otherwise
- M_ADDR  out  8  to RAM ADDR
- M_DATA  out  8  to RAM DATA
- M_MW  out  1  to RAM MW
- M_Q  in  8  from RAM Q (combinational read)
- GRANT  out  2  one-hot current owner, 2'b00 = idle
- BUSY  out  1  OR of GRANT bits

## Operation
- FSM states: IDLE, G0 (requester 0 owns port), G1 (requester 1 owns port). The state register is GRANT.
- Decision at every rising edge uses eligible requests: Rn_REQ high and n not the owner in the ending cycle (owner exclusion prevents double service while the requester still holds REQ before seeing ACK).
  - No eligible requester -> IDLE.
  - One eligible requester -> grant it.
  - Both eligible (only possible from IDLE) -> with RR_EN=1, grant the requester not equal to LAST; with RR_EN=0, grant R0.
- LAST register: updated to the granted index on every grant.
- In Gn (combinational):
  - M_ADDR = Rn_ADDR, M_DATA = Rn_WDATA.
  - M_MW = Rn_WE & Rn_REQ & ~(RO_LO <= Rn_ADDR <= RO_HI).
- In IDLE: M_ADDR = 0, M_DATA = 0, M_MW = 0.
- End of a Gn cycle with Rn_REQ still high:
  - Rn_ACK <= 1 for the next cycle.
  - Rn_RDATA <= M_Q if read.
  - Rn_ERR <= 1 if write in the RO window, else 0.
- Rn_REQ low during its own Gn cycle: access aborted, M_MW = 0, no ACK, RDATA unchanged.
- Writes/reads to 250..255 pass through unchanged; reads there return the RAM's 0.
- A requester may keep REQ high in its ACK cycle with a new address/WE (back-to-back). It is eligible at the end of that cycle.

## Timing
- Reset (async assert, sync-safe release):
  - GRANT = 00, LAST = 1 (R0 preferred first).
  - All ACK/ERR = 0, all RDATA = 0.
  - M_* = 0 immediately. A write in progress at reset assertion does not commit.
- Latency: REQ rising in cycle 0 -> grant cycle 1 (write commits at end of cycle 1) -> ACK + RDATA in cycle 2.
- Throughput: single requester gets 1 access per 2 cycles. Both requesting alternate G0/G1 with 1 access per cycle total. No starvation in either RR_EN mode, because owner exclusion forces hand-off.
- ACK is exactly one cycle wide; ERR is only ever high together with ACK.
- The simultaneous ACK-cycle request from one requester and first request from the other are both eligible. The tie is resolved by the RR_EN rule.

## Test plan
- Reset defaults: assert RESETN=0 mid-write (R0_WE=1, ADDR=10) -> M_MW drops same cycle, mem[10] unchanged, all outputs 0, GRANT=00.
- R0 write 0x5A to addr 20, then read addr 20 -> write ACK in cycle 2, read ACK cycle 4 with R0_RDATA=0x5A, ERR=0.
- Both REQ high from IDLE after reset, RR_EN=1 -> GRANT sequence 01,10,01,10...; each requester ACKs every 2 cycles.
- RR_EN=0, R0 held back-to-back, R1 requesting -> R1 granted in every R0 ACK cycle, never starved.
- R1 write to 248 -> M_MW=0, R1_ACK=1 with R1_ERR=1. R1 read 249 with IOB=0x3C -> R1_RDATA=0x3C.
- R0 drops REQ during G0 -> no ACK, M_MW low, GRANT returns to 00 next cycle.
